// File: rtl/mem_access_unit.sv
// Byte/halfword/word load-store unit in front of a word-addressed data memory.
// Misaligned accesses are split into two word reads; stores use read-modify-write.
module mem_access_unit (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [31:0] req_addr,
   input  logic [2:0]  req_size,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic [31:0] mem_access_addr,
   output logic [31:0] mem_wr_val,
   output logic        mem_write_en,
   output logic        mem_read_en,
   input  logic [31:0] mem_rd_val
);

   localparam logic [2:0] IDLE = 3'd0;
   localparam logic [2:0] RD0  = 3'd1;
   localparam logic [2:0] RD1  = 3'd2;
   localparam logic [2:0] WR0  = 3'd3;
   localparam logic [2:0] WR1  = 3'd4;
   localparam logic [2:0] RESP = 3'd5;

   logic [2:0]  state_q, state_d;
   logic [31:0] addr_q, wdata_q, buf0_q, buf1_q;
   logic [2:0]  size_q;
   logic        write_q;
   logic [31:0] addr_hold_q, wr_hold_q, rdata_hold_q;
   logic        err_hold_q;

   function automatic logic size_legal(input logic [2:0] s);
      case (s)
         3'b000, 3'b001, 3'b010, 3'b100, 3'b101: size_legal = 1'b1;
         default:                                size_legal = 1'b0;
      endcase
   endfunction

   function automatic logic [2:0] size_bytes(input logic [2:0] s);
      case (s[1:0])
         2'b00:   size_bytes = 3'd1;
         2'b01:   size_bytes = 3'd2;
         default: size_bytes = 3'd4;
      endcase
   endfunction

   logic        legal, crossing;
   logic [2:0]  nbytes;
   logic [1:0]  off;
   logic [5:0]  shamt;
   logic [31:0] w0, w1, load_val;
   logic [63:0] old64, shifted, wsh, merged;
   logic [7:0]  mask;

   always_comb begin
      legal    = size_legal(size_q);
      nbytes   = size_bytes(size_q);
      off      = addr_q[1:0];
      crossing = ({2'b00, off} + {1'b0, nbytes}) > 4'd4;
      w0       = {addr_q[31:2], 2'b00};
      w1       = w0 + 32'd4;
      shamt    = {1'b0, off, 3'b000};
      old64    = {buf1_q, buf0_q};
      shifted  = old64 >> shamt;
      case (size_q)
         3'b000:  load_val = {{24{shifted[7]}}, shifted[7:0]};
         3'b001:  load_val = {{16{shifted[15]}}, shifted[15:0]};
         3'b100:  load_val = {24'h0, shifted[7:0]};
         3'b101:  load_val = {16'h0, shifted[15:0]};
         default: load_val = shifted[31:0];
      endcase
      case (nbytes)
         3'd1:    mask = 8'h01 << off;
         3'd2:    mask = 8'h03 << off;
         default: mask = 8'h0f << off;
      endcase
      wsh    = {32'h0, wdata_q} << shamt;
      merged = old64;
      for (int i = 0; i < 8; i++) begin
         if (mask[i]) merged[8*i +: 8] = wsh[8*i +: 8];
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               if (!size_legal(req_size))                                state_d = RESP;
               else if (req_write && req_size == 3'b010 && req_addr[1:0] == 2'b00) state_d = WR0;
               else                                                      state_d = RD0;
            end
         end
         RD0:     state_d = crossing ? RD1 : (write_q ? WR0 : RESP);
         RD1:     state_d = write_q ? WR0 : RESP;
         WR0:     state_d = crossing ? WR1 : RESP;
         WR1:     state_d = RESP;
         default: state_d = IDLE;
      endcase
   end

   // Address/data/response outputs fall back to held copies so they stay stable between uses.
   always_comb begin
      req_ready    = (state_q == IDLE);
      mem_read_en  = (state_q == RD0) || (state_q == RD1);
      mem_write_en = (state_q == WR0) || (state_q == WR1);
      resp_valid   = (state_q == RESP);
      case (state_q)
         RD0, WR0: mem_access_addr = w0;
         RD1, WR1: mem_access_addr = w1;
         default:  mem_access_addr = addr_hold_q;
      endcase
      case (state_q)
         WR0:     mem_wr_val = merged[31:0];
         WR1:     mem_wr_val = merged[63:32];
         default: mem_wr_val = wr_hold_q;
      endcase
      if (state_q == RESP) begin
         resp_err   = !legal;
         resp_rdata = (legal && !write_q) ? load_val : 32'h0;
      end else begin
         resp_err   = err_hold_q;
         resp_rdata = rdata_hold_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         addr_q       <= 32'h0;
         size_q       <= 3'b000;
         write_q      <= 1'b0;
         wdata_q      <= 32'h0;
         buf0_q       <= 32'h0;
         buf1_q       <= 32'h0;
         addr_hold_q  <= 32'h0;
         wr_hold_q    <= 32'h0;
         rdata_hold_q <= 32'h0;
         err_hold_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         addr_hold_q  <= mem_access_addr;
         wr_hold_q    <= mem_wr_val;
         rdata_hold_q <= resp_rdata;
         err_hold_q   <= resp_err;
         if (state_q == IDLE && req_valid) begin
            addr_q  <= req_addr;
            size_q  <= req_size;
            write_q <= req_write;
            wdata_q <= req_wdata;
         end
         if (state_q == RD0) buf0_q <= mem_rd_val;
         if (state_q == RD1) buf1_q <= mem_rd_val;
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: behavioural word memory plus a response scoreboard.
module tb_mem_access_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready, req_write;
   logic [31:0] req_addr, req_wdata;
   logic [2:0]  req_size;
   logic        resp_valid, resp_err;
   logic [31:0] resp_rdata, mem_access_addr, mem_wr_val, mem_rd_val;
   logic        mem_write_en, mem_read_en;

   mem_access_unit dut (
      .clk             (clk),
      .rst             (rst),
      .req_valid       (req_valid),
      .req_ready       (req_ready),
      .req_write       (req_write),
      .req_addr        (req_addr),
      .req_size        (req_size),
      .req_wdata       (req_wdata),
      .resp_valid      (resp_valid),
      .resp_rdata      (resp_rdata),
      .resp_err        (resp_err),
      .mem_access_addr (mem_access_addr),
      .mem_wr_val      (mem_wr_val),
      .mem_write_en    (mem_write_en),
      .mem_read_en     (mem_read_en),
      .mem_rd_val      (mem_rd_val)
   );

   always #5 clk = ~clk;

   // Sparse memory: 0x0, 0x4, 0x8, 0xC, 0xFFFFFFFC, plus a catch-all slot.
   logic [31:0] m [0:5];
   logic        bd_we = 1'b0;
   logic [31:0] bd_addr = 32'h0, bd_val = 32'h0;

   function automatic int idx(input logic [31:0] a);
      case (a)
         32'h0:        idx = 0;
         32'h4:        idx = 1;
         32'h8:        idx = 2;
         32'hC:        idx = 3;
         32'hFFFFFFFC: idx = 4;
         default:      idx = 5;
      endcase
   endfunction

   always_comb mem_rd_val = m[idx(mem_access_addr)];

   always @(posedge clk) begin
      if (mem_write_en) m[idx(mem_access_addr)] <= mem_wr_val;
      if (bd_we)        m[idx(bd_addr)]         <= bd_val;
   end

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          lat;
      int          reads;
      int          writes;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] rd_addrs[$];
   int          n_assert = 0;
   int          n_fail   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic poke(input logic [31:0] a, input logic [31:0] v);
      @(negedge clk);
      bd_we   = 1'b1;
      bd_addr = a;
      bd_val  = v;
      @(negedge clk);
      bd_we   = 1'b0;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, " ready"}, {31'h0, req_ready}, 32'h1);
      chk({tag, " rvalid"}, {31'h0, resp_valid}, 32'h0);
      chk({tag, " err"}, {31'h0, resp_err}, 32'h0);
      chk({tag, " rdata"}, resp_rdata, 32'h0);
      chk({tag, " strobes"}, {30'h0, mem_read_en, mem_write_en}, 32'h0);
      chk({tag, " maddr"}, mem_access_addr, 32'h0);
      chk({tag, " wrval"}, mem_wr_val, 32'h0);
   endtask

   task automatic drive(input logic wr, input logic [31:0] a, input logic [2:0] sz,
                        input logic [31:0] wd);
      @(negedge clk);
      chk("ready before req", {31'h0, req_ready}, 32'h1);
      req_valid = 1'b1;
      req_write = wr;
      req_addr  = a;
      req_size  = sz;
      req_wdata = wd;
      @(posedge clk);
   endtask

   task automatic run_req(input string tag, input logic wr, input logic [31:0] a,
                          input logic [2:0] sz, input logic [31:0] wd,
                          input logic [31:0] erd, input logic eerr,
                          input int lat, input int reads, input int writes);
      exp_t e;
      int   nr, nw;
      bit   got;
      sb.push_back('{rdata: erd, err: eerr, lat: lat, reads: reads, writes: writes});
      rd_addrs.delete();
      nr  = 0;
      nw  = 0;
      got = 1'b0;
      drive(wr, a, sz, wd);
      for (int c = 1; c <= 12 && !got; c++) begin
         @(negedge clk);
         if (c == 1) req_valid = 1'b0;
         if (mem_read_en) begin
            nr++;
            rd_addrs.push_back(mem_access_addr);
         end
         if (mem_write_en) nw++;
         if (mem_read_en || mem_write_en) begin
            chk({tag, " addr align"}, {30'h0, mem_access_addr[1:0]}, 32'h0);
            chk({tag, " one strobe"}, {31'h0, mem_read_en & mem_write_en}, 32'h0);
         end
         if (resp_valid) begin
            got = 1'b1;
            e   = sb.pop_front();
            chk({tag, " rdata"}, resp_rdata, e.rdata);
            chk({tag, " err"}, {31'h0, resp_err}, {31'h0, e.err});
            chk({tag, " latency"}, c, e.lat);
            chk({tag, " reads"}, nr, e.reads);
            chk({tag, " writes"}, nw, e.writes);
         end
      end
      if (!got) begin
         chk({tag, " resp timeout"}, 32'h0, 32'h1);
         sb.delete();
      end
      @(negedge clk);
      chk({tag, " resp one cycle"}, {31'h0, resp_valid}, 32'h0);
      chk({tag, " rdata hold"}, resp_rdata, erd);
      chk({tag, " err hold"}, {31'h0, resp_err}, {31'h0, eerr});
      chk({tag, " idle ready"}, {31'h0, req_ready}, 32'h1);
   endtask

   initial begin
      int seen;
      rst       = 1'b1;
      req_valid = 1'b0;
      req_write = 1'b0;
      req_addr  = 32'h0;
      req_size  = 3'b000;
      req_wdata = 32'h0;
      #1;
      chk_reset_outputs("reset");
      poke(32'h0, 32'hc4c3c2c1);
      poke(32'h4, 32'hd4d3d2d1);
      poke(32'h8, 32'he4e3e2e1);
      poke(32'hC, 32'h0);
      poke(32'hFFFFFFFC, 32'ha4a3a2a1);
      @(negedge clk);
      chk_reset_outputs("reset held");
      rst = 1'b0;

      // Loads
      run_req("lw 5", 1'b0, 32'h5, 3'b010, 32'h0, 32'he1d4d3d2, 1'b0, 3, 2, 0);
      chk("lw 5 nreads", rd_addrs.size(), 2);
      if (rd_addrs.size() == 2) begin
         chk("lw 5 rd0 addr", rd_addrs[0], 32'h4);
         chk("lw 5 rd1 addr", rd_addrs[1], 32'h8);
      end
      run_req("lw 4", 1'b0, 32'h4, 3'b010, 32'h0, 32'hd4d3d2d1, 1'b0, 2, 1, 0);
      run_req("lh 7", 1'b0, 32'h7, 3'b001, 32'h0, 32'hffffe1d4, 1'b0, 3, 2, 0);
      run_req("lhu 7", 1'b0, 32'h7, 3'b101, 32'h0, 32'h0000e1d4, 1'b0, 3, 2, 0);
      run_req("lb 6", 1'b0, 32'h6, 3'b000, 32'h0, 32'hffffffd3, 1'b0, 2, 1, 0);
      run_req("lbu 6", 1'b0, 32'h6, 3'b100, 32'h0, 32'h000000d3, 1'b0, 2, 1, 0);
      run_req("lw wrap", 1'b0, 32'hFFFFFFFE, 3'b010, 32'h0, 32'hc2c1a4a3, 1'b0, 3, 2, 0);
      if (rd_addrs.size() == 2) chk("lw wrap rd1 addr", rd_addrs[1], 32'h0);

      // Illegal sizes
      run_req("size 011", 1'b0, 32'h4, 3'b011, 32'h0, 32'h0, 1'b1, 1, 0, 0);
      run_req("size 110", 1'b1, 32'h8, 3'b110, 32'h12345678, 32'h0, 1'b1, 1, 0, 0);
      run_req("size 111", 1'b0, 32'h1, 3'b111, 32'h0, 32'h0, 1'b1, 1, 0, 0);

      // Stores
      run_req("sh 2", 1'b1, 32'h2, 3'b001, 32'h0000beef, 32'h0, 1'b0, 3, 1, 1);
      chk("sh 2 mem0", m[0], 32'hbeefc2c1);
      poke(32'h4, 32'h0);
      poke(32'h8, 32'h0);
      run_req("sw 6", 1'b1, 32'h6, 3'b010, 32'hf7f6f5f4, 32'h0, 1'b0, 5, 2, 2);
      chk("sw 6 mem4", m[1], 32'hf5f40000);
      chk("sw 6 mem8", m[2], 32'h0000f7f6);
      poke(32'h4, 32'h0);
      run_req("sb 7", 1'b1, 32'h7, 3'b000, 32'hf7f6f5f4, 32'h0, 1'b0, 3, 1, 1);
      chk("sb 7 mem4", m[1], 32'hf4000000);
      run_req("sw 4", 1'b1, 32'h4, 3'b010, 32'h11223344, 32'h0, 1'b0, 2, 0, 1);
      chk("sw 4 mem4", m[1], 32'h11223344);
      run_req("sw wrap", 1'b1, 32'hFFFFFFFD, 3'b010, 32'h99887766, 32'h0, 1'b0, 5, 2, 2);
      chk("sw wrap memtop", m[4], 32'h887766a1);
      chk("sw wrap mem0", m[0], 32'hbeefc299);

      // Reset during RD1 of a wrapping load
      drive(1'b0, 32'hFFFFFFFE, 3'b010, 32'h0);
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      chk("rst rd1 strobe", {31'h0, mem_read_en}, 32'h1);
      chk("rst rd1 addr", mem_access_addr, 32'h0);
      rst = 1'b1;
      #1;
      chk_reset_outputs("rst in rd1");
      @(negedge clk);
      rst  = 1'b0;
      seen = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (resp_valid) seen++;
      end
      chk("rst rd1 no resp", seen, 0);
      chk("rst rd1 ready", {31'h0, req_ready}, 32'h1);

      // Reset during WR1 of a crossing store: first word lands, second does not
      poke(32'h4, 32'h0);
      poke(32'h8, 32'h0);
      drive(1'b1, 32'h6, 3'b010, 32'haabbccdd);
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      chk("rst wr1 strobe", {31'h0, mem_write_en}, 32'h1);
      chk("rst wr1 addr", mem_access_addr, 32'h8);
      rst = 1'b1;
      #1;
      chk_reset_outputs("rst in wr1");
      @(negedge clk);
      rst  = 1'b0;
      seen = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (resp_valid) seen++;
      end
      chk("rst wr1 no resp", seen, 0);
      chk("rst wr1 mem4", m[1], 32'hccdd0000);
      chk("rst wr1 mem8", m[2], 32'h0);

      // Unit still works after an abandoned access
      run_req("lw 4 after rst", 1'b0, 32'h4, 3'b010, 32'h0, 32'hccdd0000, 1'b0, 2, 1, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
